// File: rtl/obi_lsu_pkg.sv
// Shared types and helpers for the OBI load/store manager.
// Provides access-size and FSM encodings, byte-enable constants and the alignment check.
package obi_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_NONE    = 4'b0000;

  // Illegal size is folded in so a single test rejects every access that must not reach the bus.
  function automatic logic misaligned(input lsu_size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = off[0];
      WORD:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/obi_lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for the bus,
// lane extraction and sign/zero extension for returned load data.
module obi_lsu_align
  import obi_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted_s;
  lsu_size_e   size_s;

  assign size_s = lsu_size_e'(size_i);

  // Store side: byte enables and store data replicated across all lanes.
  always_comb begin
    be_o    = BE_NONE;
    wdata_o = 32'h0000_0000;
    case (size_s)
      BYTE: begin
        be_o    = BE_BYTE0 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      HALF: begin
        if (off_i[1]) begin
          be_o = BE_HALF_HI;
        end else begin
          be_o = BE_HALF_LO;
        end
        wdata_o = {2{wdata_i[15:0]}};
      end
      WORD: begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
      end
      default: begin
        be_o    = BE_NONE;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = rdata_i >> {off_i, 3'b000};
    rdata_o   = 32'h0000_0000;
    case (size_s)
      BYTE:    rdata_o = {{24{~unsigned_i & shifted_s[7]}}, shifted_s[7:0]};
      HALF:    rdata_o = {{16{~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
      WORD:    rdata_o = rdata_i;
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/obi_lsu_mgr.sv
// OBI manager for a core LSU data port: one outstanding access, IDLE -> REQ -> RESP -> DONE.
// Rejected accesses (misaligned or illegal size) skip the bus and complete with an error.
module obi_lsu_mgr
  import obi_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_valid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              obi_req_o,
  input  logic              obi_gnt_i,
  output logic [ADDR_W-1:0] obi_addr_o,
  output logic              obi_we_o,
  output logic [3:0]        obi_be_o,
  output logic [31:0]       obi_wdata_o,
  input  logic              obi_rvalid_i,
  input  logic [31:0]       obi_rdata_i,
  input  logic              obi_err_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              valid_q, err_q;
  logic [31:0]       rdata_q;

  logic              accept_s, finish_s, done_err_s;
  logic [31:0]       done_rdata_s;
  logic [3:0]        be_s;
  logic [31:0]       bus_wdata_s, ext_rdata_s;

  obi_lsu_align u_align (
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (obi_rdata_i),
    .be_o       (be_s),
    .wdata_o    (bus_wdata_s),
    .rdata_o    (ext_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the completion result captured on entry to DONE.
  always_comb begin
    state_d      = state_q;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    done_err_s   = 1'b0;
    done_rdata_s = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          accept_s = 1'b1;
          if (misaligned(lsu_size_e'(lsu_size_i), lsu_addr_i[1:0])) begin
            state_d    = DONE;
            finish_s   = 1'b1;
            done_err_s = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (obi_gnt_i) begin
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (obi_rvalid_i) begin
          state_d    = DONE;
          finish_s   = 1'b1;
          done_err_s = obi_err_i;
          if (obi_err_i || we_q) begin
            done_rdata_s = 32'h0000_0000;
          end else begin
            done_rdata_s = ext_rdata_s;
          end
        end else begin
          state_d = RESP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and completion results; rdata/err hold until the next completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      valid_q <= finish_s;
      if (accept_s) begin
        we_q    <= lsu_we_i;
        uns_q   <= lsu_unsigned_i;
        size_q  <= lsu_size_i;
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
      end
      if (finish_s) begin
        err_q   <= done_err_s;
        rdata_q <= done_rdata_s;
      end
    end
  end

  // Address-phase signals are qualified by REQ so the bus sees zeros otherwise.
  assign obi_req_o   = (state_q == REQ);
  assign obi_addr_o  = obi_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
  assign obi_we_o    = obi_req_o & we_q;
  assign obi_be_o    = obi_req_o ? be_s : BE_NONE;
  assign obi_wdata_o = obi_req_o ? bus_wdata_s : 32'h0000_0000;

  assign lsu_busy_o  = (state_q != IDLE);
  assign lsu_valid_o = valid_q;
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

endmodule

// File: tb/tb_obi_lsu_mgr.sv
// Directed vector bench for obi_lsu_mgr: table of single accesses with a cycle-level
// OBI responder, plus reset-at-startup and reset-during-RESP sequences.
module tb_obi_lsu_mgr;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_valid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
  logic [3:0]  obi_be_o;

  int checks   = 0;
  int failures = 0;

  obi_lsu_mgr #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_unsigned_i (lsu_unsigned_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_busy_o     (lsu_busy_o),
    .lsu_valid_o    (lsu_valid_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_err_o      (lsu_err_o),
    .obi_req_o      (obi_req_o),
    .obi_gnt_i      (obi_gnt_i),
    .obi_addr_o     (obi_addr_o),
    .obi_we_o       (obi_we_o),
    .obi_be_o       (obi_be_o),
    .obi_wdata_o    (obi_wdata_o),
    .obi_rvalid_i   (obi_rvalid_i),
    .obi_rdata_i    (obi_rdata_i),
    .obi_err_i      (obi_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        noise;
    logic [7:0]  gnt_at;
    logic [7:0]  rv_at;
    logic        exp_bus;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_valid"}, {31'd0, lsu_valid_o}, 32'd0);
    chk({pfx, "_busy"},  {31'd0, lsu_busy_o},  32'd0);
    chk({pfx, "_err"},   {31'd0, lsu_err_o},   32'd0);
    chk({pfx, "_rdata"}, lsu_rdata_o,          32'd0);
    chk({pfx, "_req"},   {31'd0, obi_req_o},   32'd0);
    chk({pfx, "_we"},    {31'd0, obi_we_o},    32'd0);
    chk({pfx, "_be"},    {28'd0, obi_be_o},    32'd0);
    chk({pfx, "_addr"},  obi_addr_o,           32'd0);
    chk({pfx, "_wdata"}, obi_wdata_o,          32'd0);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    int  cyc, reqc, rspc;
    bit  granted, saw, got;
    string p;
    p = $sformatf("v%0d", idx);
    lsu_we_i       = v.we;
    lsu_size_i     = v.size;
    lsu_unsigned_i = v.uns;
    lsu_addr_i     = v.addr;
    lsu_wdata_i    = v.wdata;
    lsu_req_i      = 1'b1;
    @(negedge clk);
    lsu_req_i      = 1'b0;
    lsu_addr_i     = 32'hFFFF_FFFF;
    lsu_wdata_i    = 32'h0000_0000;
    lsu_size_i     = 2'b11;
    cyc = 1; reqc = 0; rspc = 0; granted = 1'b0; saw = 1'b0; got = 1'b0;
    while (!got && cyc <= 40) begin
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      obi_rdata_i  = 32'h0000_0000;
      if (lsu_valid_o) begin
        got = 1'b1;
        chk({p, "_lat"},   cyc,                  {24'd0, v.exp_lat});
        chk({p, "_rdata"}, lsu_rdata_o,          v.exp_rdata);
        chk({p, "_err"},   {31'd0, lsu_err_o},   {31'd0, v.exp_err});
        chk({p, "_busy_done"}, {31'd0, lsu_busy_o}, 32'd1);
      end else begin
        chk({p, "_busy"}, {31'd0, lsu_busy_o}, 32'd1);
        if (obi_req_o) begin
          saw = 1'b1;
          reqc++;
          chk({p, "_addr"},  obi_addr_o,         v.exp_addr);
          chk({p, "_be"},    {28'd0, obi_be_o},  {28'd0, v.exp_be});
          chk({p, "_we"},    {31'd0, obi_we_o},  {31'd0, v.we});
          if (v.we) chk({p, "_wdata"}, obi_wdata_o, v.exp_wdata);
          if (reqc >= int'(v.gnt_at)) begin
            obi_gnt_i = 1'b1;
            granted   = 1'b1;
          end else if (v.noise) begin
            obi_rvalid_i = 1'b1;
            obi_err_i    = 1'b1;
            obi_rdata_i  = 32'hDEAD_DEAD;
          end
        end else if (granted) begin
          rspc++;
          if (rspc >= int'(v.rv_at)) begin
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = v.rdata;
            obi_err_i    = v.err;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    chk({p, "_completed"}, {31'd0, got}, 32'd1);
    chk({p, "_bus_seen"}, {31'd0, saw}, {31'd0, v.exp_bus});
    @(negedge clk);
    chk({p, "_valid_pulse"}, {31'd0, lsu_valid_o}, 32'd0);
    chk({p, "_idle"},        {31'd0, lsu_busy_o},  32'd0);
    chk({p, "_rdata_hold"},  lsu_rdata_o,          v.exp_rdata);
    chk({p, "_err_hold"},    {31'd0, lsu_err_o},   {31'd0, v.exp_err});
  endtask

  initial begin
    //            we  sz    un  addr          wdata         rdata         er no g  r  bus be       exp_addr      exp_wdata     exp_rdata     ee lat
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 32'h0,        1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1000, 32'h10, 32'hA5A5_A5A5, 32'h0,        1'b0, 8'd3};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hA512_3456, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1111, 32'h10, 32'h0,         32'hA512_3456, 1'b0, 8'd3};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,         32'h8001_1234, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1100, 32'h20, 32'h0,         32'hFFFF_8001, 1'b0, 8'd3};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,         32'h8001_1234, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1100, 32'h20, 32'h0,         32'h0000_8001, 1'b0, 8'd3};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,         32'h0,        1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 4'b0000, 32'h0,  32'h0,         32'h0,        1'b1, 8'd1};
    vecs[5]  = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,         32'h0,        1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 4'b0000, 32'h0,  32'h0,         32'h0,        1'b1, 8'd1};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h01, 32'h0,         32'h0000_8000, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b0010, 32'h0,  32'h0,         32'hFFFF_FF80, 1'b0, 8'd3};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h02, 32'h0,         32'h00FE_0000, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b0100, 32'h0,  32'h0,         32'h0000_00FE, 1'b0, 8'd3};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h16, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1100, 32'h14, 32'hBEEF_BEEF, 32'h0,        1'b0, 8'd3};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1111, 32'h40, 32'h1234_5678, 32'h0,        1'b0, 8'd3};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b1, 8'd3, 8'd3, 1'b1, 4'b1111, 32'h80, 32'h0,         32'h0BAD_F00D, 1'b0, 8'd7};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1, 4'b1111, 32'h30, 32'h0,         32'h0,        1'b1, 8'd3};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h05, 32'h0,         32'h0,        1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 4'b0000, 32'h0,  32'h0,         32'h0,        1'b1, 8'd1};
    vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_565A, 32'h0,        1'b0, 1'b0, 8'd2, 8'd2, 1'b1, 4'b0001, 32'h10, 32'h5A5A_5A5A, 32'h0,        1'b0, 8'd5};

    reset = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0;
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Abort in RESP: reset asserted after the grant, then stray responses after release.
    lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_unsigned_i = 1'b0;
    lsu_addr_i = 32'h50; lsu_req_i = 1'b1;
    @(negedge clk);
    lsu_req_i = 1'b0;
    chk("abort_req", {31'd0, obi_req_o}, 32'd1);
    obi_gnt_i = 1'b1;
    @(negedge clk);
    obi_gnt_i = 1'b0;
    chk("abort_in_resp", {31'd0, lsu_busy_o & ~obi_req_o}, 32'd1);
    reset = 1'b0;
    #1;
    chk_quiet("abort_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      obi_rvalid_i = 1'b1;
      obi_rdata_i  = 32'hFFFF_FFFF;
      obi_err_i    = 1'b1;
      @(negedge clk);
      chk($sformatf("stray%0d_valid", k), {31'd0, lsu_valid_o}, 32'd0);
      chk($sformatf("stray%0d_busy", k),  {31'd0, lsu_busy_o},  32'd0);
    end
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    @(negedge clk);
    chk_quiet("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
